// File: rtl/conbus_rr_arbiter.sv
// conbus_rr_arbiter
//   Round-robin bus-ownership arbiter for the shared Wishbone interconnect.
//   Ownership follows each master's CYC: a granted master keeps the bus until
//   its req drops. On release, the grant passes straight to the next eligible
//   master in rotation, with no idle cycle in between.
//
//   Optional macro CONBUS_ARB_WATCHDOG_EN: when defined, a watchdog revokes a
//   grant that has seen no bus_ack for TIMEOUT cycles. The revoked master is
//   then held in a stalled mask until it drops req.
//
// Ports
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   req        per-master request (mX_cyc_i)
//   bus_ack    OR of slave acks; used only by the watchdog
//   gnt        one-hot registered grant, zero when idle
//   gnt_id     binary owner index, holds the last owner when idle
//   busy       set while any gnt bit is set
//   timeout    one-cycle pulse when the watchdog revokes a grant
module conbus_rr_arbiter #(
    parameter int unsigned N_MASTERS = 7,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_ack,
    output logic [N_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_e;

    state_e                 state_q, state_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   to_q, to_d;

    logic [N_MASTERS-1:0]   stalled_q;
    logic                   wd_fire;
    logic [N_MASTERS-1:0]   eligible;
    logic                   found;
    logic [ID_W-1:0]        winner;
    logic                   load;
    int unsigned            idx;

    // gnt_q is zero in IDLE, so it masks out the current owner only while owned.
    assign eligible = req & ~stalled_q & ~gnt_q;

    // Rotating scan: first eligible index starting at last_q+1, wrapping at
    // N_MASTERS so indices beyond the master count are never visited.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned off = 1; off <= N_MASTERS; off++) begin
            idx = (32'(last_q) + off) % N_MASTERS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        busy_d  = busy_q;
        to_d    = wd_fire;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                load = found;
            end
            OWNED: begin
                // A watchdog revoke is handled exactly like the owner dropping CYC.
                if (!req[id_q] || wd_fire) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (load) begin
            gnt_d         = '0;
            gnt_d[winner] = 1'b1;
            id_d          = winner;
            last_d        = winner;
            busy_d        = 1'b1;
            state_d       = OWNED;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(N_MASTERS - 1);
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

`ifdef CONBUS_ARB_WATCHDOG_EN
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_MASTERS-1:0] stalled_d;

    assign wd_fire = (state_q == OWNED) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (load || (state_q != OWNED) || bus_ack || wd_fire) begin
            cnt_d = '0;
        end
        // Stalled bits drop once the master releases req; the revoked owner is added.
        stalled_d = stalled_q & req;
        if (wd_fire) begin
            stalled_d = stalled_d | gnt_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= '0;
            stalled_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
        end
    end
`else
    logic [CNT_W-1:0] unused_wd;

    assign wd_fire   = 1'b0;
    assign stalled_q = '0;
    assign unused_wd = CNT_W'(TIMEOUT) ^ {CNT_W{bus_ack}};
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign busy    = busy_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_conbus_rr_arbiter.sv
module tb_conbus_rr_arbiter;

    localparam int unsigned N  = 7;
    localparam int unsigned IW = 3;
`ifdef CONBUS_ARB_WATCHDOG_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic          sys_clk;
    logic          sys_rst_n;
    logic [N-1:0]  req;
    logic          bus_ack;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          timeout;

    conbus_rr_arbiter #(
        .N_MASTERS (N),
        .ID_W      (IW),
        .TIMEOUT   (TB_TIMEOUT),
        .CNT_W     (11)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .bus_ack   (bus_ack),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Packed output snapshot: {gnt, gnt_id, busy, timeout}
    typedef struct {
        logic [11:0] val;
        int          due;
        string       nm;
    } exp_t;

    exp_t        q[$];
    logic [11:0] exp_cur = '0;
    logic [11:0] prev    = '0;
    int          cyc     = 0;
    int          n_chk   = 0;
    int          n_pass  = 0;

    // Monitor: every output change must match the next queued expectation,
    // both in value and in the negedge index at which it appears.
    always @(negedge sys_clk) begin
        logic [11:0] cur;
        exp_t        e;
        cur = {gnt, gnt_id, busy, timeout};
        if (cur !== prev) begin
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_change: got gnt=%b id=%0d busy=%b to=%b @cyc %0d, want no change",
                         cur[11:5], cur[4:2], cur[1], cur[0], cyc);
            end else begin
                e = q.pop_front();
                if (cur === e.val && cyc == e.due) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b @cyc %0d, want gnt=%b id=%0d busy=%b to=%b @cyc %0d",
                             e.nm, cur[11:5], cur[4:2], cur[1], cur[0], cyc,
                             e.val[11:5], e.val[4:2], e.val[1], e.val[0], e.due);
                end
            end
            prev = cur;
        end
        cyc++;
    end

    function automatic logic [N-1:0] oh(input int unsigned i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic exp_o(input string nm, input logic [N-1:0] g, input logic [IW-1:0] id,
                         input logic b, input logic t);
        logic [11:0] v;
        exp_t        e;
        v = {g, id, b, t};
        if (v != exp_cur) begin
            e.val = v;
            e.due = cyc;
            e.nm  = nm;
            q.push_back(e);
            exp_cur = v;
        end
    endtask

    // Drive one cycle of inputs and record the outputs expected after the next edge.
    task automatic step(input string nm, input logic [N-1:0] r, input logic a,
                        input logic [N-1:0] g, input logic [IW-1:0] id,
                        input logic b, input logic t);
        @(negedge sys_clk);
        #1;
        req     = r;
        bus_ack = a;
        exp_o(nm, g, id, b, t);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        req       = r;
        bus_ack   = 1'b0;
        #1;
        n_chk++;
        if (gnt === '0 && gnt_id === '0 && busy === 1'b0 && timeout === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL async_reset: got gnt=%b id=%0d busy=%b to=%b, want all zero",
                     gnt, gnt_id, busy, timeout);
        end
        exp_o("reset", '0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        sys_rst_n = 1'b1;
        req       = '0;
        bus_ack   = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_chk++;
        if (gnt === '0 && gnt_id === '0 && busy === 1'b0 && timeout === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL reset_state: got gnt=%b id=%0d busy=%b to=%b, want all zero",
                     gnt, gnt_id, busy, timeout);
        end
        repeat (2) @(negedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // 1: single master grant and release; gnt_id holds after release
        step("t1_grant",   7'b0000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b0);
        step("t1_hold",    7'b0000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b0);
        step("t1_release", 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0);
        step("t1_idle",    7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0);

        // 2: all request, full rotation with back-to-back handovers
        do_reset(7'b0000000);
        step("t2_first", 7'b1111111, 1'b0, oh(0), 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            int unsigned nxt;
            nxt = (k + 1) % 7;
            repeat (3) step("t2_hold", 7'b1111111, 1'b1, oh(k), IW'(k), 1'b1, 1'b0);
            step("t2_handover", 7'b1111111 & ~oh(k), 1'b0, oh(nxt), IW'(nxt), 1'b1, 1'b0);
        end
        step("t2_end", 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0);

        // 3: no preemption; rotation picks 5 before 0 after owner 2
        do_reset(7'b0000000);
        step("t3_grant2",  7'b0000100, 1'b0, 7'b0000100, 3'd2, 1'b1, 1'b0);
        step("t3_nopre",   7'b0100101, 1'b0, 7'b0000100, 3'd2, 1'b1, 1'b0);
        step("t3_nopre2",  7'b0100101, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b0);
        step("t3_to5",     7'b0100001, 1'b0, 7'b0100000, 3'd5, 1'b1, 1'b0);
        step("t3_to0",     7'b0000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b0);
        step("t3_idle",    7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0);

        // 4: owner drops on the same edge another master raises
        step("t4_grant3",  7'b0001000, 1'b0, 7'b0001000, 3'd3, 1'b1, 1'b0);
        step("t4_hold",    7'b0001000, 1'b1, 7'b0001000, 3'd3, 1'b1, 1'b0);
        step("t4_to1",     7'b0000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        step("t4_idle",    7'b0000000, 1'b0, 7'b0000000, 3'd1, 1'b0, 1'b0);

        // 5: async reset mid-grant, then master 0 wins the restart
        step("t5_grant4",  7'b0010000, 1'b0, 7'b0010000, 3'd4, 1'b1, 1'b0);
        step("t5_hold",    7'b0010000, 1'b0, 7'b0010000, 3'd4, 1'b1, 1'b0);
        do_reset(7'b0010001);
        exp_o("t5_restart0", 7'b0000001, 3'd0, 1'b1, 1'b0);
        step("t5_hold0",   7'b0010001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b0);
        step("t5_idle",    7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0);

`ifdef CONBUS_ARB_WATCHDOG_EN
        // 6: watchdog revokes stalled master 1, which stays excluded until req drops
        step("t6_grant1", 7'b1000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        repeat (7) step("t6_stall", 7'b1000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        step("t6_timeout",  7'b1000010, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1);
        step("t6_pulse_end",7'b1000010, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b0);
        step("t6_idle",     7'b0000010, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0);
        step("t6_stalled",  7'b0000010, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0);
        step("t6_clear",    7'b0000000, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0);
        step("t6_regrant",  7'b0000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        step("t6_end",      7'b0000000, 1'b0, 7'b0000000, 3'd1, 1'b0, 1'b0);
`else
        // 6: without the watchdog a silent owner is never revoked
        step("t6_grant1", 7'b1000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        repeat (12) step("t6_norevoke", 7'b1000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b0);
        step("t6_to6",    7'b1000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b0);
        step("t6_end",    7'b0000000, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge sys_clk);
        #1;
        n_chk++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL missing_change: got %0d pending expectations (next %s), want 0",
                     q.size(), q[0].nm);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
